serial_frame_rx: RTL

Receiver stage downstream of the 4-bit PISO register. It takes the serial bit stream the PISO shifts out, detects framed words (start bit, data bits, stop bit), and reassembles them into parallel words. Each completed word is presented on a valid/ready output port to the next parallel consumer. Framing errors and overruns are flagged.

---
 rtl/serial_frame_pkg.sv | 13 +
 rtl/serial_frame_rx_if.sv | 28 ++
 rtl/sipo_shift.sv | 26 ++
 rtl/serial_frame_rx.sv | 117 +++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and framing constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Parallel output port of the receiver: word, valid/ready handshake and status pulses.
interface serial_frame_rx_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] pout;
    logic             pvalid;
    logic             pready;
    logic             frame_err;
    logic             overrun;

    modport master (
        output pout,
        output pvalid,
        output frame_err,
        output overrun,
        input  pready
    );

    modport slave (
        input  pout,
        input  pvalid,
        input  frame_err,
        input  overrun,
        output pready
    );

endinterface

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shift register, the receive-side mirror of the PISO.
module sipo_shift #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // LSB-first shifts toward bit 0 so the first bit ends up in q[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            if (LSB_FIRST) begin
                q <= {din, q[WIDTH-1:1]};
            end else begin
                q <= {q[WIDTH-2:0], din};
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start/data/stop detection, word reassembly and valid/ready output.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sin,
    input  logic                   bit_en,
    output logic                   busy,
    serial_frame_rx_if.master      rx_bus
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             shift_en;
    logic             cnt_clr;
    logic             stop_good;
    logic             stop_bad;
    logic             commit;

    sipo_shift #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (sin),
        .q        (shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (bit_en && sin == START_BIT) begin
                    state_nx = DATA;
                    cnt_clr  = 1'b1;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_en = 1'b1;
                    if (cnt == LAST) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                // The stop slot always returns to IDLE; it never doubles as a start bit.
                if (bit_en) begin
                    state_nx = IDLE;
                    if (sin == STOP_BIT) begin
                        stop_good = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign commit = stop_good && (!rx_bus.pvalid || rx_bus.pready);

    // A same-cycle accept frees the holding register, so the new word loads without overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_bus.pout      <= '0;
            rx_bus.pvalid    <= 1'b0;
            rx_bus.frame_err <= 1'b0;
            rx_bus.overrun   <= 1'b0;
        end else begin
            rx_bus.frame_err <= stop_bad;
            rx_bus.overrun   <= stop_good && rx_bus.pvalid && !rx_bus.pready;
            if (commit) begin
                rx_bus.pout   <= shreg;
                rx_bus.pvalid <= 1'b1;
            end else if (rx_bus.pvalid && rx_bus.pready) begin
                rx_bus.pvalid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
